// File: rtl/nbr_pixel_buffer.sv
// Neighbour pixel buffer: bottom-row line buffer, left column and corner for raster-order blocks.
// Optional macro NBUF_TOPRIGHT_EN fetches real 4x4 top-right neighbours from the line buffer.
module nbr_pixel_buffer #(
    parameter int  WIDTH   = 1280,
    parameter int  LENGTH  = 720,
    parameter int  MB_SIZE = 16,
    localparam int TOPN    = (MB_SIZE == 4) ? 8 : MB_SIZE,
    localparam int LEFTN   = (MB_SIZE == 4) ? 5 : MB_SIZE,
    localparam int MBX_N   = WIDTH / MB_SIZE,
    localparam int MBY_N   = LENGTH / MB_SIZE,
    localparam int XW      = (MBX_N > 1) ? $clog2(MBX_N) : 1,
    localparam int YW      = (MBY_N > 1) ? $clog2(MBY_N) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [MB_SIZE*MB_SIZE-1:0][7:0] reconst,
    input  logic                            nb_ack,
    output logic [TOPN-1:0][7:0]            toppixels,
    output logic [LEFTN-1:0][7:0]           leftpixels,
    output logic                            top_avail,
    output logic                            left_avail,
    output logic                            nb_valid,
    output logic [XW-1:0]                   mb_x,
    output logic [YW-1:0]                   mb_y,
    output logic                            frame_done
);

    localparam int AW  = $clog2(WIDTH);
    localparam int IW  = $clog2(MB_SIZE);
    localparam int TIW = $clog2(TOPN);
    localparam int CW  = TIW + 1;
`ifdef NBUF_TOPRIGHT_EN
    localparam bit TR_EN = 1'b1;
`else
    localparam bit TR_EN = 1'b0;
`endif
    localparam bit         IS4      = (MB_SIZE == 4);
    localparam int         READ_LEN = (IS4 && TR_EN) ? TOPN : MB_SIZE;
    localparam logic [7:0] PIX_MID  = 8'd128;

    typedef enum logic [1:0] {PRESENT, CAPTURE, WRITE, READ} state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [XW-1:0]             mbx_q;
    logic [YW-1:0]             mby_q;
    logic                      ack_seen_q;
    logic [MB_SIZE-1:0][7:0]   wrow_q;
    logic [MB_SIZE-1:0][7:0]   lcol_q;
    logic [7:0]                corner_next_q;
    logic [7:0]                corner_q;
    logic [TOPN-1:0][7:0]      top_q;
    logic [LEFTN-1:0][7:0]     left_q;
    logic                      top_avail_q;
    logic                      left_avail_q;
    logic                      nb_valid_q;
    logic                      frame_done_q;

    logic [7:0]                linebuf_q [WIDTH];

    logic [XW-1:0]             nx_d;
    logic [YW-1:0]             ny_d;
    logic                      wrap_d;
    logic                      last_col;
    logic [AW-1:0]             lb_addr;
    logic                      lb_we;
    logic [7:0]                rd_pix;
    logic [7:0]                top_pix_d;
    logic [LEFTN-1:0][7:0]     left_cap_d;

    assign last_col = (mbx_q == XW'(MBX_N - 1));
    assign lb_addr  = AW'(mbx_q) * AW'(MB_SIZE) + AW'(cnt_q);
    assign lb_we    = (state_q == WRITE);
    assign rd_pix   = linebuf_q[lb_addr];

    always_comb begin
        nx_d   = mbx_q + 1'b1;
        ny_d   = mby_q;
        wrap_d = 1'b0;
        if (last_col) begin
            nx_d = '0;
            ny_d = mby_q + 1'b1;
            if (mby_q == YW'(MBY_N - 1)) begin
                ny_d   = '0;
                wrap_d = 1'b1;
            end
        end
    end

    // Top row of frame reads nothing; 4x4 top-right falls back to top[3] past the right edge.
    always_comb begin
        top_pix_d = rd_pix;
        if (mby_q == '0)
            top_pix_d = PIX_MID;
        else if (IS4 && (cnt_q >= CW'(4)) && (!TR_EN || last_col))
            top_pix_d = top_q[3];
    end

    generate
        if (MB_SIZE == 4) begin : g_left4
            always_comb begin
                left_cap_d[0] = (mby_q != '0) ? corner_q : PIX_MID;
                for (int unsigned r = 0; r < 4; r++)
                    left_cap_d[r+1] = lcol_q[r];
            end
        end else begin : g_leftn
            always_comb left_cap_d = lcol_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (lb_we)
            linebuf_q[lb_addr] <= wrow_q[cnt_q[IW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= PRESENT;
            cnt_q         <= '0;
            mbx_q         <= '0;
            mby_q         <= '0;
            ack_seen_q    <= 1'b0;
            wrow_q        <= '0;
            lcol_q        <= '0;
            corner_next_q <= PIX_MID;
            corner_q      <= PIX_MID;
            top_q         <= {TOPN{PIX_MID}};
            left_q        <= {LEFTN{PIX_MID}};
            top_avail_q   <= 1'b0;
            left_avail_q  <= 1'b0;
            nb_valid_q    <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                PRESENT: begin
                    if (nb_ack)
                        ack_seen_q <= 1'b1;
                    if (in_valid) begin
                        ack_seen_q <= 1'b0;
                        nb_valid_q <= 1'b0;
                        state_q    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    for (int unsigned c = 0; c < MB_SIZE; c++) begin
                        wrow_q[c] <= reconst[c + MB_SIZE*(MB_SIZE-1)];
                        lcol_q[c] <= reconst[(MB_SIZE-1) + MB_SIZE*c];
                    end
                    cnt_q   <= '0;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (cnt_q == CW'(MB_SIZE - 1)) begin
                        cnt_q        <= '0;
                        mbx_q        <= nx_d;
                        mby_q        <= ny_d;
                        frame_done_q <= wrap_d;
                        corner_q     <= corner_next_q;
                        state_q      <= READ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                READ: begin
                    top_q[cnt_q[TIW-1:0]] <= top_pix_d;
                    if (IS4 && !TR_EN && (cnt_q == CW'(3)))
                        top_q[7:4] <= {4{top_pix_d}};
                    top_avail_q <= (mby_q != '0);
                    if (cnt_q == '0) begin
                        left_q       <= (mbx_q == '0) ? {LEFTN{PIX_MID}} : left_cap_d;
                        left_avail_q <= (mbx_q != '0);
                    end
                    if (cnt_q == CW'(MB_SIZE - 1))
                        corner_next_q <= top_pix_d;
                    if (cnt_q == CW'(READ_LEN - 1)) begin
                        cnt_q      <= '0;
                        nb_valid_q <= 1'b1;
                        state_q    <= PRESENT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= PRESENT;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && state_q == PRESENT && in_valid && !ack_seen_q && !nb_ack)
            $error("nbr_pixel_buffer: block captured before neighbours were acknowledged");
    end
`endif

    assign toppixels  = top_q;
    assign leftpixels = left_q;
    assign top_avail  = top_avail_q;
    assign left_avail = left_avail_q;
    assign nb_valid   = nb_valid_q;
    assign mb_x       = mbx_q;
    assign mb_y       = mby_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nbr_pixel_buffer.sv
// Directed table-driven bench for nbr_pixel_buffer on a 16x8 frame of 4x4 blocks.
module tb_nbr_pixel_buffer;

`ifdef NBUF_TOPRIGHT_EN
    localparam bit TR      = 1'b1;
    localparam int EXP_LAT = 13;
`else
    localparam bit TR      = 1'b0;
    localparam int EXP_LAT = 9;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              nb_ack = 1'b0;
    logic [15:0][7:0]  reconst = '0;
    logic [7:0][7:0]   toppixels;
    logic [4:0][7:0]   leftpixels;
    logic              top_avail, left_avail, nb_valid, frame_done;
    logic [1:0]        mb_x;
    logic [0:0]        mb_y;

    int checks = 0;
    int failures = 0;

    nbr_pixel_buffer #(.WIDTH(16), .LENGTH(8), .MB_SIZE(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .reconst(reconst), .nb_ack(nb_ack),
        .toppixels(toppixels), .leftpixels(leftpixels), .top_avail(top_avail),
        .left_avail(left_avail), .nb_valid(nb_valid), .mb_x(mb_x), .mb_y(mb_y),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]      base;
        int              ex;
        int              ey;
        bit              ta;
        bit              la;
        logic [7:0][7:0] top;
        logic [4:0][7:0] left;
        int              fd;
    } vec_t;

    vec_t vt[8];

    localparam logic [63:0] T128 = {8{8'd128}};
    localparam logic [39:0] L128 = {5{8'd128}};

    // Block pixel (c,r) = base + 4r + c: bottom row is base+12..15, right column base+3,7,11,15.
    function automatic logic [3:0][7:0] bot(input logic [7:0] b);
        for (int t = 0; t < 4; t++) bot[t] = b + 8'd12 + 8'(t);
    endfunction

    function automatic logic [4:0][7:0] lft(input logic [7:0] b, input logic [7:0] m);
        lft[0] = m;
        for (int r = 0; r < 4; r++) lft[r+1] = b + 8'd3 + 8'(4*r);
    endfunction

    function automatic logic [7:0][7:0] topv(input logic [7:0] a, input logic [7:0] rt, input bit last);
        logic [3:0][7:0] lo, hi;
        logic [7:0] l3;
        lo = bot(a);
        l3 = lo[3];
        hi = {4{l3}};
        if (TR && !last) hi = bot(rt);
        return {hi, lo};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_pres(input string tag, input int ex, input int ey, input bit ta,
                              input bit la, input logic [63:0] top, input logic [39:0] left);
        chk({tag, ".nb_valid"}, 64'(nb_valid), 64'd1);
        chk({tag, ".mb_x"}, 64'(mb_x), 64'(ex));
        chk({tag, ".mb_y"}, 64'(mb_y), 64'(ey));
        chk({tag, ".top_avail"}, 64'(top_avail), 64'(ta));
        chk({tag, ".left_avail"}, 64'(left_avail), 64'(la));
        chk({tag, ".top"}, 64'(toppixels), top);
        chk({tag, ".left"}, 64'(leftpixels), 64'(left));
    endtask

    task automatic load_block(input logic [7:0] base, input logic [7:0] step);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                reconst[c + 4*r] = base + step * 8'(4*r + c);
    endtask

    task automatic send_block(input logic [7:0] base, input logic [7:0] step, input bit inject,
                              output int lat, output int fd);
        load_block(base, step);
        @(posedge clk); #1 nb_ack = 1'b1;
        @(posedge clk); #1 nb_ack = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        chk("busy.nb_valid", 64'(nb_valid), 64'd0);
        lat = 0;
        fd  = 0;
        while (!nb_valid && lat < 100) begin
            in_valid = inject && (lat == 3);
            @(posedge clk); #1;
            lat++;
            if (frame_done) fd++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int lat, fd;

        vt[0] = '{8'd10,  1, 0, 1'b0, 1'b1, T128, lft(10, 128), 0};
        vt[1] = '{8'd30,  2, 0, 1'b0, 1'b1, T128, lft(30, 128), 0};
        vt[2] = '{8'd50,  3, 0, 1'b0, 1'b1, T128, lft(50, 128), 0};
        vt[3] = '{8'd70,  0, 1, 1'b1, 1'b0, topv(10, 30, 1'b0), L128, 0};
        vt[4] = '{8'd90,  1, 1, 1'b1, 1'b1, topv(30, 50, 1'b0), lft(90, 25), 0};
        vt[5] = '{8'd110, 2, 1, 1'b1, 1'b1, topv(50, 70, 1'b0), lft(110, 45), 0};
        vt[6] = '{8'd130, 3, 1, 1'b1, 1'b1, topv(70, 0, 1'b1), lft(130, 65), 0};
        vt[7] = '{8'd150, 0, 0, 1'b0, 1'b0, T128, L128, 1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_pres("reset", 0, 0, 1'b0, 1'b0, T128, L128);
        chk("reset.frame_done", 64'(frame_done), 64'd0);

        // Uniform block with a stray in_valid during WRITE that must be ignored.
        send_block(8'd50, 8'd0, 1'b1, lat, fd);
        chk("blk50.latency", 64'(lat), 64'(EXP_LAT));
        chk("blk50.frame_done", 64'(fd), 64'd0);
        check_pres("blk50", 1, 0, 1'b0, 1'b1, T128, {{4{8'd50}}, 8'd128});

        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_pres("reset2", 0, 0, 1'b0, 1'b0, T128, L128);

        for (int i = 0; i < 8; i++) begin
            send_block(vt[i].base, 8'd1, 1'b0, lat, fd);
            chk($sformatf("v%0d.latency", i), 64'(lat), 64'(EXP_LAT));
            chk($sformatf("v%0d.frame_done", i), 64'(fd), 64'(vt[i].fd));
            check_pres($sformatf("v%0d", i), vt[i].ex, vt[i].ey, vt[i].ta, vt[i].la,
                       vt[i].top, 64'(vt[i].left));
        end

        // Asynchronous reset in the middle of WRITE.
        load_block(8'd200, 8'd1);
        @(posedge clk); #1 nb_ack = 1'b1;
        @(posedge clk); #1 nb_ack = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midwr.nb_valid", 64'(nb_valid), 64'd0);
        #2 reset = 1'b1;
        #1 check_pres("midwr.reset", 0, 0, 1'b0, 1'b0, T128, L128);
        @(posedge clk); #1 reset = 1'b0;

        send_block(8'd10, 8'd1, 1'b0, lat, fd);
        chk("post.latency", 64'(lat), 64'(EXP_LAT));
        check_pres("post", 1, 0, 1'b0, 1'b1, T128, 64'(lft(10, 128)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
